// File: rtl/naneye_pixel_deser_if.sv
// Bit-stream in / pixel-word out bundle for naneye_pixel_deser.
// The bit side has no back-pressure: S_WREN qualifies S_DATA for exactly one cycle,
// and pix_valid qualifies pix_data/col_idx/row_idx/line_end/frame_done for one cycle.
interface naneye_pixel_deser_if #(
    parameter int PIX_W = 10,
    parameter int IDX_W = 8
);
    logic             S_DATA;
    logic             S_WREN;
    logic             frame_sync_start;
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic [IDX_W-1:0] col_idx;
    logic [IDX_W-1:0] row_idx;
    logic             line_end;
    logic             frame_done;
    logic             frame_short;
    logic             frame_err;

    modport master (
        output S_DATA, S_WREN, frame_sync_start,
        input  pix_data, pix_valid, col_idx, row_idx,
        input  line_end, frame_done, frame_short, frame_err
    );

    modport slave (
        input  S_DATA, S_WREN, frame_sync_start,
        output pix_data, pix_valid, col_idx, row_idx,
        output line_end, frame_done, frame_short, frame_err
    );
endinterface

// File: rtl/naneye_pixel_deser.sv
// Strips start/stop framing from the decoded NanEye bit stream and emits indexed pixel words.
// Optional DESER_ERR_CNT_EN adds a saturating 16-bit stop-bit error counter output.
module naneye_pixel_deser #(
    parameter int PIX_W = 10,
    parameter int COLS  = 250,
    parameter int ROWS  = 250,
    parameter int IDX_W = 8
) (
    input  logic                 SCLOCK,
    input  logic                 RESET,
    naneye_pixel_deser_if.slave  bus,
    output logic [2:0]           state_dbg
`ifdef DESER_ERR_CNT_EN
    ,
    output logic [15:0]          err_cnt
`endif
);
    localparam int BC_W = $clog2(PIX_W + 1);

    typedef enum logic [2:0] {IDLE, HUNT, SHIFT, STOP, DONE} state_t;

    state_t            state_q, state_d;
    logic              sync_q;
    logic              rise, fall;
    logic [PIX_W-1:0]  shreg_q, shreg_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  col_q, col_d, row_q, row_d;
    logic [PIX_W-1:0]  pix_data_q, pix_data_d;
    logic [IDX_W-1:0]  col_idx_q, col_idx_d, row_idx_q, row_idx_d;
    logic              pix_valid_q, pix_valid_d;
    logic              line_end_q, line_end_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_short_q, frame_short_d;
    logic              frame_err_q, frame_err_d;
    logic              last_col, last_row;

    assign rise     = bus.frame_sync_start & ~sync_q;
    assign fall     = ~bus.frame_sync_start & sync_q;
    assign last_col = (col_q == IDX_W'(COLS - 1));
    assign last_row = (row_q == IDX_W'(ROWS - 1));

    always_ff @(posedge SCLOCK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            sync_q        <= 1'b0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pix_data_q    <= '0;
            col_idx_q     <= '0;
            row_idx_q     <= '0;
            pix_valid_q   <= 1'b0;
            line_end_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_short_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= bus.frame_sync_start;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pix_data_q    <= pix_data_d;
            col_idx_q     <= col_idx_d;
            row_idx_q     <= row_idx_d;
            pix_valid_q   <= pix_valid_d;
            line_end_q    <= line_end_d;
            frame_done_q  <= frame_done_d;
            frame_short_q <= frame_short_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Window edges take priority over bit strobes, so a fall on the stop-bit cycle drops the word.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        col_d         = col_q;
        row_d         = row_q;
        pix_data_d    = pix_data_q;
        col_idx_d     = col_idx_q;
        row_idx_d     = row_idx_q;
        pix_valid_d   = 1'b0;
        line_end_d    = 1'b0;
        frame_done_d  = 1'b0;
        frame_short_d = 1'b0;
        frame_err_d   = 1'b0;
        if (rise) begin
            state_d   = HUNT;
            col_d     = '0;
            row_d     = '0;
            bit_cnt_d = '0;
        end else if (fall && state_q != IDLE) begin
            state_d       = IDLE;
            bit_cnt_d     = '0;
            frame_short_d = (state_q != DONE);
        end else if (bus.S_WREN) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.S_DATA) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                    end
                end
                SHIFT: begin
                    shreg_d   = {shreg_q[PIX_W-2:0], bus.S_DATA};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BC_W'(PIX_W - 1)) state_d = STOP;
                end
                STOP: begin
                    if (!bus.S_DATA) begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = shreg_q;
                        col_idx_d   = col_q;
                        row_idx_d   = row_q;
                        line_end_d  = last_col;
                        state_d     = HUNT;
                        if (!last_col) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            col_d = '0;
                            if (last_row) begin
                                frame_done_d = 1'b1;
                                state_d      = DONE;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pix_data    = pix_data_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.col_idx     = col_idx_q;
    assign bus.row_idx     = row_idx_q;
    assign bus.line_end    = line_end_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_short = frame_short_q;
    assign bus.frame_err   = frame_err_q;
    assign state_dbg       = state_q;

`ifdef DESER_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge SCLOCK or posedge RESET) begin
        if (RESET) begin
            err_cnt_q <= '0;
        end else if (rise) begin
            err_cnt_q <= '0;
        end else if (frame_err_d && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_naneye_pixel_deser.sv
// Directed scenarios with random data and strobe gaps, checked against a per-word frame model.
// Define DESER_ERR_CNT_EN for both RTL and bench to also check err_cnt.
module tb_naneye_pixel_deser;
    localparam int PIX_W = 10;
    localparam int COLS  = 6;
    localparam int ROWS  = 4;
    localparam int IDX_W = 8;
    localparam int W     = PIX_W + 2*IDX_W + 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    naneye_pixel_deser_if #(.PIX_W(PIX_W), .IDX_W(IDX_W)) bus ();
    logic [2:0] state_dbg;
`ifdef DESER_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    naneye_pixel_deser #(.PIX_W(PIX_W), .COLS(COLS), .ROWS(ROWS), .IDX_W(IDX_W)) dut (
        .SCLOCK    (clk),
        .RESET     (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef DESER_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int checks = 0;
    int errors = 0;
    int exp_le = 0, exp_fd = 0, exp_short = 0, exp_err = 0;
    int obs_le = 0, obs_fd = 0, obs_short = 0, obs_err = 0;
    int pix_n = 0;
    int err_since_rise = 0;
    bit win_open = 1'b0;
    bit frame_complete = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.line_end)    obs_le++;
            if (bus.frame_done)  obs_fd++;
            if (bus.frame_short) obs_short++;
            if (bus.frame_err)   obs_err++;
            if (bus.pix_valid) begin
                check("pix_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("pix_word", {bus.pix_data, bus.col_idx, bus.row_idx, bus.line_end, bus.frame_done}, mon_e);
                end
            end
        end
    end

    // reference model: one call per whole word / window edge
    task automatic model_rise();
        pix_n = 0;
        win_open = 1'b1;
        frame_complete = 1'b0;
        err_since_rise = 0;
    endtask

    task automatic model_fall();
        if (win_open && !frame_complete) exp_short++;
        win_open = 1'b0;
    endtask

    task automatic model_word(input logic [PIX_W-1:0] d, input bit stop_ok);
        int col, row;
        bit le, fd;
        if (!win_open || frame_complete) return;
        if (stop_ok) begin
            col = pix_n % COLS;
            row = pix_n / COLS;
            le  = (col == COLS - 1);
            fd  = (pix_n == COLS*ROWS - 1);
            exp_q.push_back({d, IDX_W'(col), IDX_W'(row), le, fd});
            if (le) exp_le++;
            if (fd) begin
                exp_fd++;
                frame_complete = 1'b1;
            end
            pix_n++;
        end else begin
            exp_err++;
            err_since_rise++;
        end
    endtask

    // driver tasks
    task automatic cyc(input logic wren, input logic data);
        @(negedge clk);
        bus.S_WREN = wren;
        bus.S_DATA = data;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0);
    endtask

    task automatic set_fs(input logic v);
        @(negedge clk);
        bus.S_WREN = 1'b0;
        bus.frame_sync_start = v;
        if (v) model_rise();
        else   model_fall();
        idle(1);
    endtask

    task automatic send_head(input logic [PIX_W-1:0] d, input int nbits);
        gap();
        cyc(1'b1, 1'b1);
        for (int i = PIX_W - 1; i >= PIX_W - nbits; i--) begin
            gap();
            cyc(1'b1, d[i]);
        end
    endtask

    task automatic send_word(input logic [PIX_W-1:0] d, input bit stop_ok);
        bit acc, errp;
        acc  = win_open && !frame_complete && stop_ok;
        errp = win_open && !frame_complete && !stop_ok;
        send_head(d, PIX_W);
        gap();
        model_word(d, stop_ok);
        cyc(1'b1, !stop_ok);
        @(posedge clk);
        #1;
        check("latency_pix_valid", bus.pix_valid, acc);
        check("err_pulse", bus.frame_err, errp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PIX_W-1:0] d;
        rst = 1'b1;
        bus.S_WREN = 1'b0;
        bus.S_DATA = 1'b0;
        bus.frame_sync_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_pix_data", bus.pix_data, 0);
        check("rst_idx", {bus.col_idx, bus.row_idx}, 0);
        check("rst_pulses", {bus.line_end, bus.frame_done, bus.frame_short, bus.frame_err}, 0);
        check("rst_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // single word 0x2AA at col 0 / row 0, then window closes early
        set_fs(1'b1);
        send_word(10'h2AA, 1'b1);
        set_fs(1'b0);
        idle(2);
        check("short_after_one", obs_short, exp_short);

        // idle zeros before a start bit are ignored
        set_fs(1'b1);
        repeat (3) cyc(1'b1, 1'b0);
        send_word(10'h001, 1'b1);

        // complete frame with data = pixel index, then words in DONE are ignored
        set_fs(1'b0);
        set_fs(1'b1);
        for (int i = 0; i < COLS*ROWS; i++) send_word(PIX_W'(i % 1024), 1'b1);
        send_word(10'h155, 1'b1);
        send_word(10'h0F0, 1'b1);
        set_fs(1'b0);
        idle(2);
        check("frame_done_cnt", obs_fd, exp_fd);
        check("line_end_cnt", obs_le, exp_le);
        check("no_short_after_done", obs_short, exp_short);

        // stop-bit violation followed by a good word at col 0
        set_fs(1'b1);
        send_word(PIX_W'($urandom_range(0, 1023)), 1'b0);
        send_word(10'h3FF, 1'b1);
        idle(2);
        check("err_cnt_pulses", obs_err, exp_err);
`ifdef DESER_ERR_CNT_EN
        check("err_cnt_value", err_cnt, err_since_rise);
`endif

        // partial word discarded on fall, next frame restarts at col 0
        for (int i = 0; i < 8; i++) send_word(PIX_W'($urandom_range(0, 1023)), 1'b1);
        send_head(10'h2D3, 5);
        set_fs(1'b0);
        idle(2);
        check("short_partial", obs_short, exp_short);
        send_word(10'h111, 1'b1);
        set_fs(1'b1);
        send_word(10'h222, 1'b1);

        // fall on the stop-bit strobe: fall wins
        send_head(10'h333, PIX_W);
        @(negedge clk);
        bus.S_WREN = 1'b1;
        bus.S_DATA = 1'b0;
        bus.frame_sync_start = 1'b0;
        model_fall();
        @(posedge clk);
        #1;
        check("fall_stop_no_pix", bus.pix_valid, 0);
        check("fall_stop_short", bus.frame_short, 1);
        idle(2);

        // reset mid-shift clears outputs; bits ignored until a new rise
        set_fs(1'b1);
        send_word(10'h3C3, 1'b1);
        send_head(10'h0AA, 4);
        @(negedge clk);
        rst = 1'b1;
        bus.S_WREN = 1'b0;
        bus.frame_sync_start = 1'b0;
        win_open = 1'b0;
        #1;
        check("rstmid_outputs", {bus.pix_data, bus.col_idx, bus.row_idx, bus.pix_valid,
                                 bus.line_end, bus.frame_done, bus.frame_short, bus.frame_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_word(10'h2F1, 1'b1);
        send_word(10'h1E2, 1'b1);

        // random frame with occasional stop-bit errors
        set_fs(1'b1);
        for (int i = 0; i < COLS*ROWS + 6; i++) begin
            d = PIX_W'($urandom_range(0, 1023));
            send_word(d, $urandom_range(0, 7) != 0);
        end
        idle(2);
`ifdef DESER_ERR_CNT_EN
        check("err_cnt_random", err_cnt, err_since_rise);
`endif
        set_fs(1'b0);
        idle(3);

        check("queue_drained", exp_q.size(), 0);
        check("final_le", obs_le, exp_le);
        check("final_fd", obs_fd, exp_fd);
        check("final_short", obs_short, exp_short);
        check("final_err", obs_err, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
